// File: rtl/emif_calbus_pkg.sv
// Shared constants for the EMIF calibration-bus register file: address map,
// STATUS bit positions and the calibration state encoding.
package emif_calbus_pkg;

  localparam logic [19:0] ADDR_STATUS  = 20'h00100;
  localparam logic [19:0] ADDR_SCRATCH = 20'h00101;
  localparam logic [19:0] ADDR_TXN_CNT = 20'h00102;

  localparam int STATUS_PASS_BIT = 0;
  localparam int STATUS_FAIL_BIT = 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } cal_state_e;

endpackage

// File: rtl/emif_calbus_wdog.sv
// Calibration watchdog: counts consecutive idle RUN cycles and flags a timeout
// on the cycle that would make the count reach TIMEOUT_CYCLES.
module emif_calbus_wdog #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic activity,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;

  assign timeout = run && !activity && (idle_cnt == LAST_IDLE);

  always_ff @(posedge clk) begin
    if (rst || !run || activity) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/emif_calbus_regfile.sv
// Calibration-bus register file: host-loaded sequencer parameter table, STATUS,
// SCRATCH, TXN_CNT and the LOAD/RUN/DONE/FAIL calibration FSM.
// Define EMIF_CALBUS_WDOG_EN to add the idle watchdog that forces FAIL in RUN.
module emif_calbus_regfile
  import emif_calbus_pkg::*;
#(
  parameter int TBL_WORDS      = 128,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     calbus_clk,
  input  logic                     calbus_rst,
  input  logic                     calbus_read,
  input  logic                     calbus_write,
  input  logic [19:0]              calbus_address,
  input  logic [31:0]              calbus_wdata,
  output logic [31:0]              calbus_rdata,
  output logic [32*TBL_WORDS-1:0]  calbus_seq_param_tbl,
  input  logic                     host_tbl_we,
  input  logic [6:0]               host_tbl_addr,
  input  logic [31:0]              host_tbl_wdata,
  input  logic                     host_arm,
  output logic                     cal_done,
  output logic                     cal_fail,
  output logic [1:0]               cal_state,
  output logic [7:0]               err_cnt
);

  localparam int AW = (TBL_WORDS > 1) ? $clog2(TBL_WORDS) : 1;

  cal_state_e  state, state_next;
  logic [31:0] tbl [TBL_WORDS];
  logic [1:0]  status;
  logic [31:0] scratch;
  logic [31:0] txn_cnt;
  logic [31:0] rd_word;
  logic        in_tbl, wr_status, err_event, timeout, arm_to_load;

  // Strobes are single-cycle accesses: every asserted cycle is one access, no
  // backpressure. A cycle with several error causes still counts as one error.
  assign in_tbl      = calbus_address < 20'(TBL_WORDS);
  assign wr_status   = calbus_write && (calbus_address == ADDR_STATUS);
  assign arm_to_load = host_arm && ((state == ST_DONE) || (state == ST_FAIL));
  assign err_event   = (calbus_read && calbus_write)
                    || (calbus_write && in_tbl)
                    || (wr_status && (state != ST_RUN));

`ifdef EMIF_CALBUS_WDOG_EN
  emif_calbus_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (calbus_clk),
    .rst      (calbus_rst),
    .run      (state == ST_RUN),
    .activity (calbus_read || calbus_write),
    .timeout  (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (host_arm) state_next = ST_RUN;
      ST_RUN: begin
        if (wr_status && calbus_wdata[STATUS_FAIL_BIT])      state_next = ST_FAIL;
        else if (wr_status && calbus_wdata[STATUS_PASS_BIT]) state_next = ST_DONE;
        else if (timeout)                                    state_next = ST_FAIL;
      end
      ST_DONE, ST_FAIL: if (host_arm) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (in_tbl)                                rd_word = tbl[calbus_address[AW-1:0]];
    else if (calbus_address == ADDR_STATUS)    rd_word = {30'd0, status};
    else if (calbus_address == ADDR_SCRATCH)   rd_word = scratch;
    else if (calbus_address == ADDR_TXN_CNT)   rd_word = txn_cnt;
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_rst) begin
      state        <= ST_LOAD;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
      calbus_rdata <= '0;
      status       <= '0;
      scratch      <= '0;
      txn_cnt      <= '0;
      err_cnt      <= '0;
      for (int i = 0; i < TBL_WORDS; i++) tbl[i] <= '0;
    end else begin
      state    <= state_next;
      cal_done <= (state_next == ST_DONE);
      cal_fail <= (state_next == ST_FAIL);
      if (calbus_read && !calbus_write) calbus_rdata <= rd_word;
      if (calbus_write) txn_cnt <= txn_cnt + 32'd1;
      if (err_event && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (calbus_write && (calbus_address == ADDR_SCRATCH)) scratch <= calbus_wdata;
      if ((state == ST_RUN) && wr_status) status <= calbus_wdata[1:0];
      else if (timeout)                   status[STATUS_FAIL_BIT] <= 1'b1;
      else if (arm_to_load)               status <= '0;
      if ((state == ST_LOAD) && host_tbl_we && (int'(host_tbl_addr) < TBL_WORDS))
        tbl[host_tbl_addr] <= host_tbl_wdata;
    end
  end

  for (genvar g = 0; g < TBL_WORDS; g++) begin : g_tbl_out
    assign calbus_seq_param_tbl[32*g +: 32] = tbl[g];
  end

  assign cal_state = state;

endmodule
